uart_rx_line_capt: RTL
======================

Name: uart_rx_line_capt

Overview:
- Receive-side counterpart of the UART TX line feeder.
- Consumes single bytes from the UART RX FIFO through a valid/ready handshake and assembles printable ASCII characters into a fixed-width, space-padded line.
- On a CR or LF terminator, presents the line as a (chars+2)-byte register ending in CR LF, in exactly the format the TX feeder's i_dat_ascii_line accepts, and holds it until the consumer acknowledges.
- Lets a host type commands/text that the design can echo or parse.

Parameters:
- PARM_LINE_CHARS, 32, maximum printable characters per line; output register is (PARM_LINE_CHARS+2)*8 bits.
- PARM_LEN_BITS, 6, width of the character count; must hold 0..PARM_LINE_CHARS.

Ports:
- i_clk_20mhz  input  1  system clock, 20 MHz
- i_rstn_20mhz  input  1  asynchronous active-low reset
- i_rx_data  input  8  received byte from UART RX FIFO
- i_rx_valid  input  1  i_rx_data valid; byte accepted when i_rx_valid & o_rx_ready
- o_rx_ready  output  1  block can accept a byte this cycle
- o_dat_ascii_line  output  (PARM_LINE_CHARS+2)*8  captured line; first char in MSB byte, pad 0x20, last two bytes 0x0D 0x0A
- o_line_len  output  PARM_LEN_BITS  count of captured characters
- o_line_valid  output  1  level; line complete and stable
- o_line_trunc  output  1  level; line exceeded PARM_LINE_CHARS and was truncated
- i_line_ack  input  1  consumer done with line; honoured only while o_line_valid=1

Behaviour:
- Reset (async, i_rstn_20mhz=0): state ST_LINE_COLL, count=0, line=all 0x20 chars + 0x0D0A, trunc flag=0. Outputs: o_line_valid=0, o_line_trunc=0, o_line_len=0, o_rx_ready=1 (Moore decode of ST_LINE_COLL).
- States are registered; all outputs are Moore, decoded from the state and aux registers.
- ST_LINE_COLL: o_rx_ready=1. On an accepted byte b:
  - b in 0x20..0x7E, count<PARM_LINE_CHARS: write b to char slot [count] (slot 0 = MSB byte); count+1.
  - b printable, count==PARM_LINE_CHARS: set trunc; go to ST_LINE_DISC; b is discarded.
  - b=0x08 or 0x7F, count>0: count-1; slot [count-1] restored to 0x20.
  - b=0x08 or 0x7F, count==0: ignored.
  - b=0x0D or 0x0A, count>0: go to ST_LINE_HOLD.
  - b=0x0D or 0x0A, count==0: ignored. This makes CRLF and LFCR produce one line, and blank lines are dropped.
  - Any other byte (<0x20, >0x7E): ignored.
- ST_LINE_DISC: o_rx_ready=1. Every accepted byte is dropped, including backspace. A 0x0D/0x0A moves to ST_LINE_HOLD with count=PARM_LINE_CHARS and trunc=1.
- ST_LINE_HOLD: o_rx_ready=0, o_line_valid=1, o_line_trunc=trunc. o_dat_ascii_line and o_line_len are stable for the whole state.
  - i_line_ack=1: go to ST_LINE_COLL, count=0, line reset to spaces+CRLF, trunc=0.
- Latency:
  - Terminator accepted in cycle N gives o_line_valid=1 in cycle N+1.
  - Ack in cycle M gives o_line_valid=0 and o_rx_ready=1 in cycle M+1.
  - Minimum of one cycle per accepted byte; back-to-back valid bytes are accepted every cycle.
- i_line_ack outside ST_LINE_HOLD: ignored.
- i_rx_valid while o_rx_ready=0: byte is not consumed and stays in the upstream FIFO.
- The trailing CR LF bytes of o_dat_ascii_line are constant and never overwritten.
- o_line_len never exceeds PARM_LINE_CHARS and never wraps; decrement at 0 is suppressed.
- Reset asserted mid-line or during hold: line is lost, all state returns to reset values immediately.
- Tying o_line_valid to the TX feeder's go input and feeding back the feeder's completion as i_line_ack yields a line echo. The hold-until-ack rule guarantees the line is stable through the feeder's capture.

Test Plan:
- "HI" 0x48 0x49 then 0x0D -> o_line_valid=1 one cycle after 0x0D; o_line_len=2; line MSB bytes 0x48 0x49, then 30x 0x20, then 0x0D 0x0A; o_line_trunc=0; o_rx_ready=0.
- Ack the above, then send 0x0A (stray LF from CRLF) -> ignored, o_line_valid stays 0, o_line_len=0; next "A"+0x0D gives o_line_len=1, MSB byte 0x41.
- "ABC" 0x08 "D" 0x0D -> o_line_len=3, chars "ABD"; 0x08 at count 0 before typing -> no change.
- 40 bytes of 0x5A then 0x0D -> o_line_len=32, all 32 chars 0x5A, o_line_trunc=1; after ack o_line_trunc=0.
- During hold, drive i_rx_valid=1 with 0x41 for 5 cycles -> o_rx_ready=0, line unchanged; i_line_ack pulse -> o_rx_ready=1 next cycle and 0x41 accepted into slot 0.
- Pull i_rstn_20mhz low after 10 chars mid-line -> outputs at reset values asynchronously; after release, "X"+0x0D yields o_line_len=1.

Source files
------------

// File: rtl/uart_rx_line_capt_if.sv
// uart_rx_line_capt_if: byte handshake from the RX FIFO and captured-line output of the line capture block.
interface uart_rx_line_capt_if #(
    parameter int PARM_LINE_CHARS = 32,
    parameter int PARM_LEN_BITS   = 6
);
    logic [7:0]                       i_rx_data;
    logic                             i_rx_valid;
    logic                             o_rx_ready;
    logic [(PARM_LINE_CHARS+2)*8-1:0] o_dat_ascii_line;
    logic [PARM_LEN_BITS-1:0]         o_line_len;
    logic                             o_line_valid;
    logic                             o_line_trunc;
    logic                             i_line_ack;

    modport slave (
        input  i_rx_data, i_rx_valid, i_line_ack,
        output o_rx_ready, o_dat_ascii_line, o_line_len, o_line_valid, o_line_trunc
    );

    modport master (
        output i_rx_data, i_rx_valid, i_line_ack,
        input  o_rx_ready, o_dat_ascii_line, o_line_len, o_line_valid, o_line_trunc
    );
endinterface

// File: rtl/uart_rx_line_capt.sv
// uart_rx_line_capt: assembles printable RX bytes into a space-padded, CR LF terminated line held until acknowledged.
module uart_rx_line_capt #(
    parameter int PARM_LINE_CHARS = 32,
    parameter int PARM_LEN_BITS   = 6
) (
    input  logic                 i_clk_20mhz,
    input  logic                 i_rstn_20mhz,
    uart_rx_line_capt_if.slave   bus
);
    localparam int LW = (PARM_LINE_CHARS + 2) * 8;
    localparam logic [1:0] ST_LINE_COLL = 2'd0;
    localparam logic [1:0] ST_LINE_DISC = 2'd1;
    localparam logic [1:0] ST_LINE_HOLD = 2'd2;
    localparam logic [PARM_LEN_BITS-1:0] MAX_LEN = PARM_LEN_BITS'(PARM_LINE_CHARS);

    logic [1:0]               state_q, state_d;
    logic [PARM_LEN_BITS-1:0] cnt_q, cnt_d;
    logic                     trunc_q, trunc_d;
    logic [7:0]               char_q [PARM_LINE_CHARS];
    logic [7:0]               char_d [PARM_LINE_CHARS];
    logic [LW-1:0]            line;
    logic [7:0]               b;
    logic                     rdy, acc, is_prn, is_bs, is_term;

    assign b       = bus.i_rx_data;
    assign rdy     = state_q != ST_LINE_HOLD;
    assign acc     = bus.i_rx_valid && rdy;
    assign is_prn  = b >= 8'h20 && b <= 8'h7E;
    assign is_bs   = b == 8'h08 || b == 8'h7F;
    assign is_term = b == 8'h0D || b == 8'h0A;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        char_d  = char_q;
        if (state_q == ST_LINE_HOLD) begin
            if (bus.i_line_ack) begin
                state_d = ST_LINE_COLL;
                cnt_d   = '0;
                trunc_d = 1'b0;
                for (int i = 0; i < PARM_LINE_CHARS; i++) char_d[i] = 8'h20;
            end
        end else if (acc && state_q == ST_LINE_DISC) begin
            // overflowed line: everything up to the terminator is dropped
            if (is_term) begin
                state_d = ST_LINE_HOLD;
                cnt_d   = MAX_LEN;
                trunc_d = 1'b1;
            end
        end else if (acc) begin
            if (is_prn && cnt_q < MAX_LEN) begin
                for (int i = 0; i < PARM_LINE_CHARS; i++)
                    if (cnt_q == PARM_LEN_BITS'(i)) char_d[i] = b;
                cnt_d = cnt_q + PARM_LEN_BITS'(1);
            end else if (is_prn) begin
                trunc_d = 1'b1;
                state_d = ST_LINE_DISC;
            end else if (is_bs && cnt_q != '0) begin
                for (int i = 0; i < PARM_LINE_CHARS; i++)
                    if (cnt_q == PARM_LEN_BITS'(i + 1)) char_d[i] = 8'h20;
                cnt_d = cnt_q - PARM_LEN_BITS'(1);
            end else if (is_term && cnt_q != '0) begin
                state_d = ST_LINE_HOLD;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q <= ST_LINE_COLL;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            for (int i = 0; i < PARM_LINE_CHARS; i++) char_q[i] <= 8'h20;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            char_q  <= char_d;
        end
    end

    // slot 0 lands in the most significant byte; CR LF is fixed in the low bytes
    always_comb begin
        line       = '0;
        line[15:0] = 16'h0D0A;
        for (int i = 0; i < PARM_LINE_CHARS; i++) line[LW-1-8*i -: 8] = char_q[i];
    end

    assign bus.o_rx_ready       = rdy;
    assign bus.o_line_valid     = state_q == ST_LINE_HOLD;
    assign bus.o_line_trunc     = state_q == ST_LINE_HOLD && trunc_q;
    assign bus.o_line_len       = cnt_q;
    assign bus.o_dat_ascii_line = line;
endmodule
